// File: rtl/pong_pkg.sv
// Shared types and codes for the pong game-flow controller.
package pong_pkg;

  typedef enum logic [1:0] {
    NEWGAME,
    SERVE,
    PLAY,
    OVER
  } game_state_t;

  localparam logic [1:0] TXT_NONE  = 2'd0;
  localparam logic [1:0] TXT_START = 2'd1;
  localparam logic [1:0] TXT_READY = 2'd2;
  localparam logic [1:0] TXT_OVER  = 2'd3;

  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_P1   = 2'd1;
  localparam logic [1:0] WIN_P2   = 2'd2;

endpackage

// File: rtl/pong_frame_timer.sv
// 8-bit frame down-counter, saturating at zero; load wins over tick.
module pong_frame_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       tick,
  output logic       zero
);

  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (tick && (count != '0)) begin
      count <= count - 8'd1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game-flow FSM: new-game, serve, play, game-over; scores and overlay text.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned WIN_SCORE    = 9,
  parameter int unsigned SERVE_FRAMES = 120,
  parameter int unsigned OVER_FRAMES  = 180
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [3:0] btn,
  input  logic       pts_1,
  input  logic       pts_2,
  output logic       gra_still,
  output logic [3:0] score_1,
  output logic [3:0] score_2,
  output logic [1:0] winner,
  output logic [1:0] text_sel,
  output logic       game_active
);

  localparam logic [3:0] WIN_VAL    = 4'(WIN_SCORE);
  localparam logic [7:0] SERVE_LOAD = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0] OVER_LOAD  = 8'(OVER_FRAMES - 1);

  game_state_t state, next_state;
  logic [3:0]  next_score_1, next_score_2;
  logic [1:0]  next_winner;
  logic        btn_any_q;
  logic        press;
  logic        timer_load;
  logic [7:0]  timer_val;
  logic        timer_zero;

  // btn_any_q resets high so a button held through reset is not a press
  assign press = (|btn) & ~btn_any_q;

  pong_frame_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (timer_val),
    .tick     (frame_tick),
    .zero     (timer_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= NEWGAME;
      score_1   <= '0;
      score_2   <= '0;
      winner    <= WIN_NONE;
      btn_any_q <= 1'b1;
    end else begin
      state     <= next_state;
      score_1   <= next_score_1;
      score_2   <= next_score_2;
      winner    <= next_winner;
      btn_any_q <= |btn;
    end
  end

  always_comb begin
    next_state   = state;
    next_score_1 = score_1;
    next_score_2 = score_2;
    next_winner  = winner;
    timer_load   = 1'b0;
    timer_val    = '0;
    case (state)
      NEWGAME: begin
        if (press) begin
          next_state   = SERVE;
          timer_load   = 1'b1;
          timer_val    = SERVE_LOAD;
          next_score_1 = '0;
          next_score_2 = '0;
          next_winner  = WIN_NONE;
        end
      end
      SERVE: begin
        if (frame_tick && timer_zero) next_state = PLAY;
      end
      PLAY: begin
        // Leaving PLAY on the first asserted cycle counts each point once
        if (pts_1) begin
          next_score_1 = score_1 + 4'd1;
          timer_load   = 1'b1;
          if (next_score_1 == WIN_VAL) begin
            next_state  = OVER;
            next_winner = WIN_P1;
            timer_val   = OVER_LOAD;
          end else begin
            next_state = SERVE;
            timer_val  = SERVE_LOAD;
          end
        end else if (pts_2) begin
          next_score_2 = score_2 + 4'd1;
          timer_load   = 1'b1;
          if (next_score_2 == WIN_VAL) begin
            next_state  = OVER;
            next_winner = WIN_P2;
            timer_val   = OVER_LOAD;
          end else begin
            next_state = SERVE;
            timer_val  = SERVE_LOAD;
          end
        end
      end
      OVER: begin
        if (press && timer_zero) begin
          next_state   = NEWGAME;
          next_score_1 = '0;
          next_score_2 = '0;
          next_winner  = WIN_NONE;
        end
      end
      default: next_state = NEWGAME;
    endcase
  end

  always_comb begin
    gra_still   = 1'b1;
    text_sel    = TXT_START;
    game_active = 1'b0;
    case (state)
      NEWGAME: text_sel = TXT_START;
      SERVE:   text_sel = TXT_READY;
      PLAY: begin
        gra_still   = 1'b0;
        text_sel    = TXT_NONE;
        game_active = 1'b1;
      end
      OVER:    text_sel = TXT_OVER;
      default: text_sel = TXT_START;
    endcase
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl against a phase/frame-count model.
module tb_pong_game_ctrl;

  localparam int WIN = 2;
  localparam int SF  = 3;
  localparam int OF  = 4;

  localparam int PH_NEW   = 0;
  localparam int PH_SERVE = 1;
  localparam int PH_PLAY  = 2;
  localparam int PH_OVER  = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       frame_tick = 1'b0;
  logic [3:0] btn = '0;
  logic       pts_1 = 1'b0;
  logic       pts_2 = 1'b0;
  logic       gra_still;
  logic [3:0] score_1, score_2;
  logic [1:0] winner, text_sel;
  logic       game_active;

  int n_checks = 0;
  int n_fail   = 0;

  // model: phase, frames seen in this phase, scores, winner, previous any-button
  int m_phase = PH_NEW;
  int m_frames = 0;
  int m_s1 = 0, m_s2 = 0, m_win = 0;
  bit m_prev_any = 1'b1;

  pong_game_ctrl #(.WIN_SCORE(WIN), .SERVE_FRAMES(SF), .OVER_FRAMES(OF)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .btn(btn),
    .pts_1(pts_1), .pts_2(pts_2), .gra_still(gra_still),
    .score_1(score_1), .score_2(score_2), .winner(winner),
    .text_sel(text_sel), .game_active(game_active)
  );

  always #5 clk = ~clk;

  logic [13:0] dut_out;
  assign dut_out = {gra_still, score_1, score_2, winner, text_sel, game_active};

  function automatic logic [13:0] exp_out();
    logic [1:0] t;
    t = (m_phase == PH_NEW) ? 2'd1 : (m_phase == PH_SERVE) ? 2'd2 :
        (m_phase == PH_PLAY) ? 2'd0 : 2'd3;
    return {(m_phase != PH_PLAY), 4'(m_s1), 4'(m_s2), 2'(m_win), t, (m_phase == PH_PLAY)};
  endfunction

  task automatic model_update();
    bit any, pr;
    any = (btn != 4'd0);
    pr  = any && !m_prev_any;
    if (reset) begin
      m_phase = PH_NEW; m_frames = 0; m_s1 = 0; m_s2 = 0; m_win = 0; m_prev_any = 1'b1;
      return;
    end
    m_prev_any = any;
    case (m_phase)
      PH_NEW: if (pr) begin m_phase = PH_SERVE; m_frames = 0; end
      PH_SERVE: if (frame_tick) begin
        m_frames++;
        if (m_frames == SF) m_phase = PH_PLAY;
      end
      PH_PLAY: begin
        if (pts_1) begin
          m_s1++;
          m_frames = 0;
          if (m_s1 == WIN) begin m_win = 1; m_phase = PH_OVER; end
          else m_phase = PH_SERVE;
        end else if (pts_2) begin
          m_s2++;
          m_frames = 0;
          if (m_s2 == WIN) begin m_win = 2; m_phase = PH_OVER; end
          else m_phase = PH_SERVE;
        end
      end
      default: begin
        // restart accepted once OF-1 frames have elapsed since entering game-over
        if (pr && (m_frames >= OF - 1)) begin
          m_phase = PH_NEW; m_s1 = 0; m_s2 = 0; m_win = 0;
        end else if (frame_tick && (m_frames < OF - 1)) begin
          m_frames++;
        end
      end
    endcase
  endtask

  task automatic step(input logic [3:0] b, input logic ft, input logic p1,
                      input logic p2, input logic rst);
    btn = b; frame_tick = ft; pts_1 = p1; pts_2 = p2; reset = rst;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    step(4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic goto_play();
    step(4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < SF; i++) begin
      step(4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      step(4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset();
    step(4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (dut_out !== 14'b1_0000_0000_00_01_0) begin
      n_fail++;
      $display("FAIL reset_state: got %b expected %b", dut_out, 14'b1_0000_0000_00_01_0);
    end
    step(4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_held_button();
    step(4'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (text_sel !== 2'd1 || gra_still !== 1'b1) begin
      n_fail++;
      $display("FAIL held_btn_newgame: got text_sel=%0d gra_still=%0b expected 1 1", text_sel, gra_still);
    end
    step(4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (text_sel !== 2'd2 || gra_still !== 1'b1 || dut_out !== exp_out()) begin
      n_fail++;
      $display("FAIL press_to_serve: got %b expected %b", dut_out, exp_out());
    end
  endtask

  task automatic test_serve();
    do_reset();
    step(4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(4'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    step(4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (gra_still !== 1'b1 || score_1 !== 4'd0) begin
      n_fail++;
      $display("FAIL serve_hold: got gra_still=%0b score_1=%0d expected 1 0", gra_still, score_1);
    end
    step(4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (gra_still !== 1'b0 || game_active !== 1'b1 || dut_out !== exp_out()) begin
      n_fail++;
      $display("FAIL serve_release: got %b expected %b", dut_out, exp_out());
    end
  endtask

  task automatic test_hold_pts();
    do_reset();
    goto_play();
    for (int i = 0; i < 5; i++) begin
      step(4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      if (i == 0) begin
        n_checks++;
        if (game_active !== 1'b0 || text_sel !== 2'd2) begin
          n_fail++;
          $display("FAIL pts_exit_play: got game_active=%0b text_sel=%0d expected 0 2", game_active, text_sel);
        end
      end
    end
    n_checks++;
    if (score_1 !== 4'd1 || dut_out !== exp_out()) begin
      n_fail++;
      $display("FAIL pts_held_once: got score_1=%0d out=%b expected 1 %b", score_1, dut_out, exp_out());
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    goto_play();
    step(4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (score_1 !== 4'd1 || score_2 !== 4'd0) begin
      n_fail++;
      $display("FAIL pts_priority: got %0d/%0d expected 1/0", score_1, score_2);
    end
  endtask

  task automatic test_win_p2();
    do_reset();
    goto_play();
    step(4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    goto_play();
    step(4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (score_2 !== 4'd2 || winner !== 2'd2 || text_sel !== 2'd3) begin
      n_fail++;
      $display("FAIL p2_wins: got score_2=%0d winner=%0d text=%0d expected 2 2 3", score_2, winner, text_sel);
    end
    step(4'd8, 1'b0, 1'b0, 1'b0, 1'b0);
    step(4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(4'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (text_sel !== 2'd3 || winner !== 2'd2) begin
      n_fail++;
      $display("FAIL early_press_ignored: got text=%0d winner=%0d expected 3 2", text_sel, winner);
    end
    step(4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (dut_out !== 14'b1_0000_0000_00_01_0 || dut_out !== exp_out()) begin
      n_fail++;
      $display("FAIL restart_newgame: got %b expected %b", dut_out, exp_out());
    end
  endtask

  task automatic test_reset_mid_play();
    do_reset();
    goto_play();
    step(4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    goto_play();
    step(4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (dut_out !== 14'b1_0000_0000_00_01_0) begin
      n_fail++;
      $display("FAIL reset_mid_play: got %b expected %b", dut_out, 14'b1_0000_0000_00_01_0);
    end
  endtask

  task automatic test_random();
    logic [3:0] b;
    logic p1, p2, ft, rst;
    b = '0; p1 = 1'b0; p2 = 1'b0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) b = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) p1 = ~p1;
      if ($urandom_range(0, 9) == 0) p2 = ~p2;
      ft  = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 599) == 0);
      step(b, ft, p1, p2, rst);
      n_checks++;
      if (dut_out !== exp_out()) begin
        n_fail++;
        $display("FAIL random_cycle_%0d: got %b expected %b", i, dut_out, exp_out());
      end
    end
  endtask

  initial begin
    test_reset();
    test_held_button();
    test_serve();
    test_hold_pts();
    test_simultaneous();
    test_win_p2();
    test_reset_mid_play();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
